// File: rtl/ddr3_readback_checker.sv
// ddr3_readback_checker: drains the DDR3 readback FIFO and compares every 256-bit word
// against a seeded Galois LFSR pattern, accumulating word/bit error statistics.
module ddr3_readback_checker #(
    parameter int          CNT_W         = 32,
    parameter logic [31:0] POLY          = 32'h80200003,
    parameter bit          STOP_ON_ERROR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] target_words,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic             fifo_valid,
    input  logic [255:0]     fifo_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] words_checked,
    output logic [CNT_W-1:0] error_words,
    output logic [CNT_W-1:0] error_bits,
    output logic [CNT_W-1:0] first_err_index,
    output logic [2:0]       first_err_lane,
    output logic [31:0]      first_err_actual
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             rd_pend_q, rd_pend_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic [255:0]     xor_q, xor_d;
    logic [255:0]     data_q, data_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [CNT_W-1:0] err_words_q, err_words_d;
    logic [CNT_W-1:0] err_bits_q, err_bits_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [2:0]       first_lane_q, first_lane_d;
    logic [31:0]      first_act_q, first_act_d;
    logic             captured_q, captured_d;

    logic [255:0]     expected;
    logic [31:0]      lfsr_walk;
    logic [8:0]       pop_cnt;
    logic [2:0]       low_lane;
    logic [CNT_W:0]   bits_sum;
    logic             accept;
    logic             underflow;
    logic             word_err;
    logic             stop_now;

    // Expected word: eight consecutive LFSR states, lane 0 first; the ninth state seeds the next word.
    always_comb begin
        lfsr_walk = lfsr_q;
        expected  = '0;
        for (int k = 0; k < 8; k++) begin
            expected[32*k +: 32] = lfsr_walk;
            lfsr_walk = (lfsr_walk >> 1) ^ (lfsr_walk[0] ? POLY : 32'h0);
        end
    end

    always_comb begin
        pop_cnt  = '0;
        low_lane = '0;
        for (int i = 0; i < 256; i++) begin
            pop_cnt = pop_cnt + {8'd0, xor_q[i]};
        end
        for (int k = 7; k >= 0; k--) begin
            if (xor_q[32*k +: 32] != 32'h0) begin
                low_lane = 3'(k);
            end
        end
    end

    assign accept    = rd_pend_q && fifo_valid;
    assign underflow = rd_pend_q && !fifo_valid;
    assign word_err  = cmp_valid_q && (xor_q != '0);
    assign stop_now  = STOP_ON_ERROR && word_err;
    assign bits_sum  = {1'b0, err_bits_q} + (CNT_W+1)'(pop_cnt);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        target_d     = target_q;
        issued_d     = issued_q;
        xor_d        = xor_q;
        data_d       = data_q;
        words_d      = words_q;
        err_words_d  = err_words_q;
        err_bits_d   = err_bits_q;
        first_idx_d  = first_idx_q;
        first_lane_d = first_lane_q;
        first_act_d  = first_act_q;
        captured_d   = captured_q;
        cmp_valid_d  = accept;
        fifo_rd_en   = 1'b0;

        if (accept) begin
            xor_d  = fifo_data ^ expected;
            data_d = fifo_data;
            lfsr_d = lfsr_walk;
        end

        // words_q still holds the index of the word being retired this cycle.
        if (cmp_valid_q) begin
            words_d = words_q + 1'b1;
            if (word_err) begin
                err_words_d = err_words_q + 1'b1;
                err_bits_d  = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
                if (!captured_q) begin
                    captured_d   = 1'b1;
                    first_idx_d  = words_q;
                    first_lane_d = low_lane;
                    first_act_d  = data_q[32*low_lane +: 32];
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    lfsr_d       = (seed == 32'h0) ? 32'h1 : seed;
                    target_d     = target_words;
                    issued_d     = '0;
                    words_d      = '0;
                    err_words_d  = '0;
                    err_bits_d   = '0;
                    first_idx_d  = '0;
                    first_lane_d = '0;
                    first_act_d  = '0;
                    captured_d   = 1'b0;
                end
            end
            RUN: begin
                fifo_rd_en = !fifo_empty && (issued_q < target_q) && !stop_now;
                issued_d   = issued_q + CNT_W'(fifo_rd_en) - CNT_W'(underflow);
                if (stop_now || ((issued_q == target_q) && !underflow)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_pend_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_pend_d = fifo_rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= 32'h1;
            target_q     <= '0;
            issued_q     <= '0;
            rd_pend_q    <= 1'b0;
            cmp_valid_q  <= 1'b0;
            xor_q        <= '0;
            data_q       <= '0;
            words_q      <= '0;
            err_words_q  <= '0;
            err_bits_q   <= '0;
            first_idx_q  <= '0;
            first_lane_q <= '0;
            first_act_q  <= '0;
            captured_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            target_q     <= target_d;
            issued_q     <= issued_d;
            rd_pend_q    <= rd_pend_d;
            cmp_valid_q  <= cmp_valid_d;
            xor_q        <= xor_d;
            data_q       <= data_d;
            words_q      <= words_d;
            err_words_q  <= err_words_d;
            err_bits_q   <= err_bits_d;
            first_idx_q  <= first_idx_d;
            first_lane_q <= first_lane_d;
            first_act_q  <= first_act_d;
            captured_q   <= captured_d;
        end
    end

    assign busy             = (state_q == RUN) || (state_q == DRAIN);
    assign done             = (state_q == DONE);
    assign pass             = done && (err_words_q == '0);
    assign words_checked    = words_q;
    assign error_words      = err_words_q;
    assign error_bits       = err_bits_q;
    assign first_err_index  = first_idx_q;
    assign first_err_lane   = first_lane_q;
    assign first_err_actual = first_act_q;
endmodule
